// File: rtl/dec8b10b_sync_ctrl.sv
// dec8b10b_sync_ctrl: 8b/10b symbol classification, RD tracking, comma sync FSM and 1-entry byte output stage.
// Define DEC8B10B_SYNC_STATS_EN to build the saturating symbol-error counter behind err_count_o.
module dec8b10b_sync_ctrl #(
   parameter int COMMA_CNT_P  = 3,
   parameter int ERR_THRESH_P = 4,
   parameter int GOOD_CNT_P   = 4
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic [9:0]  sym_i,
   input  logic        sym_v_i,
   output logic [9:0]  dec_sym_o,
   output logic        dec_en_o,
   input  logic [7:0]  dec_byte_i,
   output logic [7:0]  out_byte_o,
   output logic        out_v_o,
   input  logic        out_ready_i,
   output logic        sync_o,
   output logic [1:0]  state_o,
   output logic        rd_o,
   output logic        sym_err_o,
   output logic        overflow_o,
   input  logic        clear_stats_i,
   output logic [15:0] err_count_o
);
   localparam int CW = $clog2(COMMA_CNT_P + 1);
   localparam int EW = $clog2(ERR_THRESH_P + 1);
   localparam int GW = $clog2(GOOD_CNT_P + 1);
   localparam logic [CW-1:0] COMMA_L = CW'(COMMA_CNT_P);
   localparam logic [EW-1:0] ERR_L   = EW'(ERR_THRESH_P);
   localparam logic [GW-1:0] GOOD_L  = GW'(GOOD_CNT_P);

   typedef enum logic [1:0] {LOS = 2'b00, ACQ = 2'b01, SYNC = 2'b10, CHECK = 2'b11} state_t;

   state_t        state_q, state_d;
   logic          rd_q, rd_d, out_v_q, out_v_d, sym_err_q, sym_err_d, ovf_q, ovf_d;
   logic [7:0]    out_byte_q, out_byte_d;
   logic [CW-1:0] ccnt_q, ccnt_d;
   logic [EW-1:0] ecnt_q, ecnt_d;
   logic [GW-1:0] gcnt_q, gcnt_d;
   logic [3:0]    ones;
   logic [2:0]    ones_h, ones_l;
   logic          comma, err, data, full;

   assign ones   = 4'($countones(sym_i));
   assign ones_h = 3'($countones(sym_i[9:5]));
   assign ones_l = 3'($countones(sym_i[4:0]));
   assign comma  = sym_i == 10'h0FA || sym_i == 10'h305;
   // RD violations only count once the link has left LOS
   assign err    = ones < 4'd4 || ones > 4'd6 ||
                   (state_q != LOS && ((ones == 4'd6 && rd_q) || (ones == 4'd4 && !rd_q)));
   assign data   = !comma && !err && ((ones_h == 3'd3 && ones_l == 3'd2) || (ones_h == 3'd2 && ones_l == 3'd3));
   assign full   = out_v_q && !out_ready_i;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= LOS;
         rd_q       <= 1'b0;
         out_v_q    <= 1'b0;
         out_byte_q <= '0;
         sym_err_q  <= 1'b0;
         ovf_q      <= 1'b0;
         ccnt_q     <= '0;
         ecnt_q     <= '0;
         gcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         rd_q       <= rd_d;
         out_v_q    <= out_v_d;
         out_byte_q <= out_byte_d;
         sym_err_q  <= sym_err_d;
         ovf_q      <= ovf_d;
         ccnt_q     <= ccnt_d;
         ecnt_q     <= ecnt_d;
         gcnt_q     <= gcnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rd_d       = rd_q;
      ccnt_d     = ccnt_q;
      ecnt_d     = ecnt_q;
      gcnt_d     = gcnt_q;
      sym_err_d  = sym_v_i && err;
      ovf_d      = dec_en_o && full;
      out_v_d    = dec_en_o || full;
      out_byte_d = dec_en_o && !full ? dec_byte_i : out_byte_q;
      if (sym_v_i) begin
         rd_d = ones == 4'd6 ? 1'b1 : ones == 4'd4 ? 1'b0 : rd_q;
         case (state_q)
            LOS: if (comma) begin
               state_d = ACQ;
               ccnt_d  = CW'(1);
            end
            ACQ: if (err) state_d = LOS;
               else if (comma) begin
                  ccnt_d = ccnt_q + CW'(1);
                  if (ccnt_q + CW'(1) == COMMA_L) state_d = SYNC;
               end
            SYNC: if (err) begin
               state_d = CHECK;
               ecnt_d  = EW'(1);
               gcnt_d  = '0;
            end
            CHECK: if (err) begin
                  ecnt_d = ecnt_q + EW'(1);
                  gcnt_d = '0;
                  if (ecnt_q + EW'(1) == ERR_L) state_d = LOS;
               end else if (gcnt_q + GW'(1) == GOOD_L) begin
                  gcnt_d = '0;
                  ecnt_d = ecnt_q - EW'(1);
                  if (ecnt_q == EW'(1)) state_d = SYNC;
               end else gcnt_d = gcnt_q + GW'(1);
         endcase
      end
   end

   always_comb begin
      dec_sym_o = sym_i;
      dec_en_o  = sym_v_i && state_q[1] && data;
      sync_o    = state_q[1];
      state_o   = state_q;
   end

   assign rd_o       = rd_q;
   assign out_v_o    = out_v_q;
   assign out_byte_o = out_byte_q;
   assign sym_err_o  = sym_err_q;
   assign overflow_o = ovf_q;

`ifdef DEC8B10B_SYNC_STATS_EN
   logic [15:0] err_cnt_q;
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) err_cnt_q <= '0;
      else if (clear_stats_i) err_cnt_q <= '0;
      else if (sym_v_i && err && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
   end
   assign err_count_o = err_cnt_q;
`else
   logic unused_clear;
   assign unused_clear = clear_stats_i;
   assign err_count_o  = '0;
`endif
endmodule
